// File: rtl/ip_stride_pkg.sv
// rtl/ip_stride_pkg.sv - shared widths, tracker types and issue FSM states for the IP-stride prefetcher
package ip_stride_pkg;

   localparam int DEF_ADDR_W     = 64;
   localparam int DEF_LOG2_BLOCK = 6;
   localparam int DEF_LOG2_PAGE  = 12;
   localparam int DEF_CONF_W     = 2;
   localparam int DEF_CLA_W      = DEF_ADDR_W - DEF_LOG2_BLOCK;

   typedef logic        [DEF_CLA_W-1:0]  cla_t;
   typedef logic signed [DEF_CLA_W-1:0]  stride_t;
   typedef logic        [DEF_CONF_W-1:0] conf_t;

   typedef struct packed {
      logic                  valid;
      logic [DEF_ADDR_W-1:0] ip;
      cla_t                  last_cla;
      stride_t               stride;
      conf_t                 conf;
   } tracker_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } pf_state_e;

endpackage

// File: rtl/ip_stride_prefetcher_q_tracker_table.sv
// rtl/ip_stride_prefetcher_q_tracker_table.sv - fully associative per-IP stride tracker with age-based LRU
// Presents post-update stride/confidence for the access being offered; state commits on fire_i.
module ip_stride_tracker_table
   import ip_stride_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int LOG2_BLOCK = DEF_LOG2_BLOCK,
   parameter int TRACKERS   = 16,
   parameter int CONF_W     = DEF_CONF_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            fire_i,
   input  logic [ADDR_W-1:0]               ip_i,
   input  logic [ADDR_W-LOG2_BLOCK-1:0]    cla_i,
   output logic                            train_o,
   output logic signed [ADDR_W-LOG2_BLOCK-1:0] stride_o,
   output logic [CONF_W-1:0]               conf_o
);

   localparam int CLA_W = ADDR_W - LOG2_BLOCK;
   localparam int IDX_W = $clog2(TRACKERS);

   logic [TRACKERS-1:0]       valid_q, valid_d;
   logic [ADDR_W-1:0]         ip_q       [TRACKERS];
   logic [ADDR_W-1:0]         ip_d       [TRACKERS];
   logic [CLA_W-1:0]          last_cla_q [TRACKERS];
   logic [CLA_W-1:0]          last_cla_d [TRACKERS];
   logic signed [CLA_W-1:0]   stride_q   [TRACKERS];
   logic signed [CLA_W-1:0]   stride_d   [TRACKERS];
   logic [CONF_W-1:0]         conf_q     [TRACKERS];
   logic [CONF_W-1:0]         conf_d     [TRACKERS];
   logic [IDX_W-1:0]          age_q      [TRACKERS];
   logic [IDX_W-1:0]          age_d      [TRACKERS];

   logic                      hit;
   logic [IDX_W-1:0]          hit_idx;
   logic                      free_found;
   logic [IDX_W-1:0]          free_idx;
   logic [IDX_W-1:0]          victim_idx;
   logic [IDX_W-1:0]          idx;
   logic signed [CLA_W-1:0]   new_stride;
   logic signed [CLA_W-1:0]   post_stride;
   logic [CONF_W-1:0]         post_conf;

   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      victim_idx = '0;
      for (int i = 0; i < TRACKERS; i++) begin
         if (valid_q[i] && (ip_q[i] == ip_i)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (age_q[i] == IDX_W'(TRACKERS - 1)) begin
            victim_idx = IDX_W'(i);
         end
      end
      // Scan downward so the lowest-index invalid entry wins.
      for (int i = TRACKERS - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      idx = hit ? hit_idx : (free_found ? free_idx : victim_idx);
   end

   always_comb begin
      new_stride  = $signed(cla_i - last_cla_q[hit_idx]);
      post_stride = stride_q[hit_idx];
      post_conf   = conf_q[hit_idx];
      if (new_stride != '0) begin
         if (new_stride == stride_q[hit_idx]) begin
            if (post_conf != '1) begin
               post_conf = post_conf + CONF_W'(1);
            end
         end else if (post_conf == '0) begin
            post_stride = new_stride;
         end else begin
            post_conf = post_conf - CONF_W'(1);
         end
      end
   end

   assign train_o  = hit && (new_stride != '0);
   assign stride_o = post_stride;
   assign conf_o   = post_conf;

   always_comb begin
      valid_d    = valid_q;
      ip_d       = ip_q;
      last_cla_d = last_cla_q;
      stride_d   = stride_q;
      conf_d     = conf_q;
      age_d      = age_q;
      if (fire_i) begin
         for (int i = 0; i < TRACKERS; i++) begin
            if (age_q[i] < age_q[idx]) begin
               age_d[i] = age_q[i] + IDX_W'(1);
            end
         end
         age_d[idx] = '0;
         if (!hit) begin
            valid_d[idx]    = 1'b1;
            ip_d[idx]       = ip_i;
            last_cla_d[idx] = cla_i;
            stride_d[idx]   = '0;
            conf_d[idx]     = '0;
         end else if (new_stride != '0) begin
            last_cla_d[idx] = cla_i;
            stride_d[idx]   = post_stride;
            conf_d[idx]     = post_conf;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < TRACKERS; i++) begin
            ip_q[i]       <= '0;
            last_cla_q[i] <= '0;
            stride_q[i]   <= '0;
            conf_q[i]     <= '0;
            age_q[i]      <= IDX_W'(i);
         end
      end else begin
         valid_q    <= valid_d;
         ip_q       <= ip_d;
         last_cla_q <= last_cla_d;
         stride_q   <= stride_d;
         conf_q     <= conf_d;
         age_q      <= age_d;
      end
   end

endmodule

// File: rtl/ip_stride_prefetcher_q.sv
// rtl/ip_stride_prefetcher_q.sv - IP-stride prefetcher top: issue FSM and same-page candidate generation
// Define PREF_CROSS_PAGE_EN to drop the page filter and issue all cfg_degree_i candidates.
module ip_stride_prefetcher_q
   import ip_stride_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int LOG2_BLOCK  = DEF_LOG2_BLOCK,
   parameter int LOG2_PAGE   = DEF_LOG2_PAGE,
   parameter int TRACKERS    = 16,
   parameter int MAX_DEGREE  = 4,
   parameter int CONF_W      = DEF_CONF_W,
   parameter int CONF_THRESH = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              acc_valid_i,
   output logic                              acc_ready_o,
   input  logic [ADDR_W-1:0]                 addr_i,
   input  logic [ADDR_W-1:0]                 ip_i,
   input  logic [$clog2(MAX_DEGREE+1)-1:0]   cfg_degree_i,
   output logic                              pref_valid_o,
   input  logic                              pref_ready_i,
   output logic [ADDR_W-1:0]                 pref_addr_o
);

   localparam int CLA_W = ADDR_W - LOG2_BLOCK;
   localparam int DEG_W = $clog2(MAX_DEGREE + 1);

   pf_state_e                state_q, state_d;
   logic [CLA_W-1:0]         cur_cla_q, cur_cla_d;
   logic [CLA_W-1:0]         stride_q, stride_d;
   logic [DEG_W-1:0]         n_q, n_d;
   logic [DEG_W-1:0]         k_q, k_d;

   logic                     acc_fire;
   logic [CLA_W-1:0]         cla;
   logic                     tbl_train;
   logic signed [CLA_W-1:0]  tbl_stride;
   logic [CONF_W-1:0]        tbl_conf;
   logic [DEG_W-1:0]         deg_eff;
   logic [DEG_W-1:0]         n_cand;
   logic                     issue_go;
   logic                     unused_addr_bits;

   assign acc_ready_o      = (state_q == IDLE);
   assign acc_fire         = acc_valid_i && acc_ready_o;
   assign cla              = addr_i[ADDR_W-1:LOG2_BLOCK];
   assign unused_addr_bits = ^addr_i[LOG2_BLOCK-1:0];
   assign deg_eff          = (cfg_degree_i > DEG_W'(MAX_DEGREE)) ? DEG_W'(MAX_DEGREE) : cfg_degree_i;

   ip_stride_tracker_table #(
      .ADDR_W     (ADDR_W),
      .LOG2_BLOCK (LOG2_BLOCK),
      .TRACKERS   (TRACKERS),
      .CONF_W     (CONF_W)
   ) u_table (
      .clk      (clk),
      .rst      (rst),
      .fire_i   (acc_fire),
      .ip_i     (ip_i),
      .cla_i    (cla),
      .train_o  (tbl_train),
      .stride_o (tbl_stride),
      .conf_o   (tbl_conf)
   );

`ifdef PREF_CROSS_PAGE_EN
   assign n_cand = deg_eff;
`else
   logic [CLA_W-1:0]  cand_cla;
   logic [ADDR_W-1:0] cand_addr;
   logic              crossed;

   // Count leading candidates on the trigger's page; the first crossing ends the run.
   always_comb begin
      n_cand    = '0;
      crossed   = 1'b0;
      cand_cla  = '0;
      cand_addr = '0;
      for (int k = 1; k <= MAX_DEGREE; k++) begin
         cand_cla  = cla + CLA_W'(k) * $unsigned(tbl_stride);
         cand_addr = {cand_cla, {LOG2_BLOCK{1'b0}}};
         if ((DEG_W'(k) <= deg_eff) && !crossed) begin
            if (cand_addr[ADDR_W-1:LOG2_PAGE] == addr_i[ADDR_W-1:LOG2_PAGE]) begin
               n_cand = DEG_W'(k);
            end else begin
               crossed = 1'b1;
            end
         end
      end
   end
`endif

   assign issue_go = acc_fire && tbl_train
                     && (tbl_conf >= CONF_W'(CONF_THRESH)) && (n_cand != '0);

   always_comb begin
      state_d   = state_q;
      cur_cla_d = cur_cla_q;
      stride_d  = stride_q;
      n_d       = n_q;
      k_d       = k_q;
      case (state_q)
         IDLE: begin
            if (issue_go) begin
               state_d   = ISSUE;
               cur_cla_d = cla + $unsigned(tbl_stride);
               stride_d  = $unsigned(tbl_stride);
               n_d       = n_cand;
               k_d       = DEG_W'(1);
            end
         end
         ISSUE: begin
            if (pref_ready_i) begin
               if (k_q == n_q) begin
                  state_d = IDLE;
               end else begin
                  k_d       = k_q + DEG_W'(1);
                  cur_cla_d = cur_cla_q + stride_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cur_cla_q <= '0;
         stride_q  <= '0;
         n_q       <= '0;
         k_q       <= '0;
      end else begin
         state_q   <= state_d;
         cur_cla_q <= cur_cla_d;
         stride_q  <= stride_d;
         n_q       <= n_d;
         k_q       <= k_d;
      end
   end

   assign pref_valid_o = (state_q == ISSUE);
   assign pref_addr_o  = pref_valid_o ? {cur_cla_q, {LOG2_BLOCK{1'b0}}} : '0;

endmodule

// File: tb/tb_ip_stride_prefetcher_q.sv
// tb/tb_ip_stride_prefetcher_q.sv - directed self-checking bench for ip_stride_prefetcher_q (TRACKERS=4)
module tb_ip_stride_prefetcher_q;

   logic        clk = 1'b0;
   logic        rst;
   logic        acc_valid;
   logic        acc_ready;
   logic [63:0] addr;
   logic [63:0] ip;
   logic [2:0]  cfg_deg;
   logic        pref_valid;
   logic        pref_ready;
   logic [63:0] pref_addr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ip_stride_prefetcher_q #(.TRACKERS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .acc_valid_i  (acc_valid),
      .acc_ready_o  (acc_ready),
      .addr_i       (addr),
      .ip_i         (ip),
      .cfg_degree_i (cfg_deg),
      .pref_valid_o (pref_valid),
      .pref_ready_i (pref_ready),
      .pref_addr_o  (pref_addr)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic pv, input logic [63:0] pa, input logic ar);
      check({tag, ".pref_valid"}, {63'd0, pref_valid}, {63'd0, pv});
      check({tag, ".pref_addr"},  pref_addr, pa);
      check({tag, ".acc_ready"},  {63'd0, acc_ready}, {63'd0, ar});
   endtask

   // One accepted access; returns on the negedge after the accepting edge.
   task automatic acc(input logic [63:0] a_ip, input logic [63:0] a_addr);
      @(negedge clk);
      acc_valid = 1'b1;
      ip        = a_ip;
      addr      = a_addr;
      @(negedge clk);
      acc_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      acc_valid  = 1'b0;
      ip         = '0;
      addr       = '0;
      cfg_deg    = 3'd2;
      pref_ready = 1'b1;
      #2;
      chk_out("reset", 1'b0, 64'h0, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      // training, degree 2
      acc(64'h400, 64'h1000); chk_out("train_a1", 1'b0, 64'h0, 1'b1);
      acc(64'h400, 64'h1040); chk_out("train_a2", 1'b0, 64'h0, 1'b1);
      acc(64'h400, 64'h1080); chk_out("train_a3", 1'b0, 64'h0, 1'b1);
      acc(64'h400, 64'h10C0); chk_out("train_p1", 1'b1, 64'h1100, 1'b0);
      @(negedge clk);         chk_out("train_p2", 1'b1, 64'h1140, 1'b0);
      @(negedge clk);         chk_out("train_done", 1'b0, 64'h0, 1'b1);

      // backpressure with a competing access held on the input
      do_reset();
      pref_ready = 1'b0;
      acc(64'h400, 64'h1000);
      acc(64'h400, 64'h1040);
      acc(64'h400, 64'h1080);
      acc(64'h400, 64'h10C0);
      acc_valid = 1'b1;
      ip        = 64'h999;
      addr      = 64'h5000;
      chk_out("bp_hold0", 1'b1, 64'h1100, 1'b0);
      @(negedge clk); chk_out("bp_hold1", 1'b1, 64'h1100, 1'b0);
      @(negedge clk); chk_out("bp_hold2", 1'b1, 64'h1100, 1'b0);
      pref_ready = 1'b1;
      @(negedge clk); chk_out("bp_last", 1'b1, 64'h1140, 1'b0);
      @(negedge clk); chk_out("bp_done", 1'b0, 64'h0, 1'b1);
      @(negedge clk);
      acc_valid = 1'b0;

      // asynchronous reset while ISSUE is stalled
      pref_ready = 1'b0;
      acc(64'h400, 64'h1100); chk_out("rmid_issue", 1'b1, 64'h1140, 1'b0);
      #2 rst = 1'b1;
      #1 chk_out("rmid_reset", 1'b0, 64'h0, 1'b1);
      @(negedge clk);
      rst        = 1'b0;
      pref_ready = 1'b1;
      acc(64'h400, 64'h1140); chk_out("retrain_a1", 1'b0, 64'h0, 1'b1);
      acc(64'h400, 64'h1180); chk_out("retrain_a2", 1'b0, 64'h0, 1'b1);
      acc(64'h400, 64'h11C0); chk_out("retrain_a3", 1'b0, 64'h0, 1'b1);
      acc(64'h400, 64'h1200); chk_out("retrain_p1", 1'b1, 64'h1240, 1'b0);
      @(negedge clk);         chk_out("retrain_p2", 1'b1, 64'h1280, 1'b0);
      @(negedge clk);         chk_out("retrain_done", 1'b0, 64'h0, 1'b1);

      // page filter at the top line of a page
      acc(64'h500, 64'h1F00);
      acc(64'h500, 64'h1F40);
      acc(64'h500, 64'h1F80);
      acc(64'h500, 64'h1FC0);
`ifdef PREF_CROSS_PAGE_EN
      chk_out("xpage_p1", 1'b1, 64'h2000, 1'b0);
      @(negedge clk); chk_out("xpage_p2", 1'b1, 64'h2040, 1'b0);
      @(negedge clk); chk_out("xpage_done", 1'b0, 64'h0, 1'b1);
`else
      chk_out("page_c1", 1'b0, 64'h0, 1'b1);
      @(negedge clk); chk_out("page_c2", 1'b0, 64'h0, 1'b1);
`endif

      // negative stride, second candidate leaves the page
      acc(64'h600, 64'h3100);
      acc(64'h600, 64'h30C0);
      acc(64'h600, 64'h3080);
      acc(64'h600, 64'h3040); chk_out("neg_p1", 1'b1, 64'h3000, 1'b0);
`ifdef PREF_CROSS_PAGE_EN
      @(negedge clk); chk_out("neg_p2", 1'b1, 64'h2FC0, 1'b0);
`endif
      @(negedge clk); chk_out("neg_done", 1'b0, 64'h0, 1'b1);

      // degree above MAX_DEGREE clamps to 4, degree 0 disables issue
      cfg_deg = 3'd7;
      acc(64'h700, 64'h6000);
      acc(64'h700, 64'h6040);
      acc(64'h700, 64'h6080);
      acc(64'h700, 64'h60C0); chk_out("clamp_p1", 1'b1, 64'h6100, 1'b0);
      @(negedge clk);         chk_out("clamp_p2", 1'b1, 64'h6140, 1'b0);
      @(negedge clk);         chk_out("clamp_p3", 1'b1, 64'h6180, 1'b0);
      @(negedge clk);         chk_out("clamp_p4", 1'b1, 64'h61C0, 1'b0);
      @(negedge clk);         chk_out("clamp_done", 1'b0, 64'h0, 1'b1);
      cfg_deg = 3'd0;
      acc(64'h700, 64'h6100); chk_out("deg0", 1'b0, 64'h0, 1'b1);

      // LRU: A..D trained to conf 1, E evicts A
      do_reset();
      cfg_deg = 3'd1;
      for (int j = 0; j < 4; j++) begin
         for (int a = 0; a < 3; a++) begin
            acc(64'hA0 + 64'(j) * 64'h10, 64'h10000 * 64'(j + 1) + 64'(a) * 64'h40);
         end
      end
      acc(64'hE0, 64'h50000); chk_out("lru_e", 1'b0, 64'h0, 1'b1);
      for (int j = 1; j < 4; j++) begin
         acc(64'hA0 + 64'(j) * 64'h10, 64'h10000 * 64'(j + 1) + 64'hC0);
         chk_out("lru_kept", 1'b1, 64'h10000 * 64'(j + 1) + 64'h100, 1'b0);
         @(negedge clk);
         chk_out("lru_kept_done", 1'b0, 64'h0, 1'b1);
      end
      acc(64'hA0, 64'h100C0); chk_out("lru_a_evicted", 1'b0, 64'h0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ip_stride_prefetcher_q.md
Name: ip_stride_prefetcher_q

Overview:
- Next-generation IP-stride L1/L2 prefetcher. Tracks per-IP cache-line stride with a saturating confidence counter and a parametrised tracker table.
- On a confident access, queues up to cfg_degree_i same-page prefetch candidates and emits them one per valid/ready handshake toward the prefetch queue.
- Sits between the demand-access monitor and the cache's prefetch request port.

Parameters:
- ADDR_W, 64, address and IP width
- LOG2_BLOCK, 6, log2 cache-line bytes
- LOG2_PAGE, 12, log2 page bytes (page-boundary filter)
- TRACKERS, 16, tracker entries, fully associative, power of 2 >= 2
- MAX_DEGREE, 4, maximum prefetches per trigger
- CONF_W, 2, confidence counter width
- CONF_THRESH, 2, minimum confidence to issue

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- acc_valid_i  in  1  demand access present
- acc_ready_o  out  1  block can accept an access
- addr_i  in  ADDR_W  demand byte address
- ip_i  in  ADDR_W  instruction pointer of the access
- cfg_degree_i  in  $clog2(MAX_DEGREE+1)  runtime degree, sampled at accept; values above MAX_DEGREE clamp to MAX_DEGREE; 0 disables issue
- pref_valid_o  out  1  prefetch address valid
- pref_ready_i  in  1  consumer accepts prefetch
- pref_addr_o  out  ADDR_W  line-aligned prefetch byte address

Behaviour:
- Reset (async, immediate):
  - all trackers invalid, age[i]=i, FSM=IDLE
  - pref_valid_o=0, pref_addr_o=0, acc_ready_o=1 during and after reset
  - a reset during ISSUE drops all pending candidates
- Address split:
  - cla = addr_i >> LOG2_BLOCK, width CLA_W = ADDR_W-LOG2_BLOCK
  - stride = signed(cla - last_cla), modulo 2^CLA_W
- Tracker entry: valid, ip, last_cla, stride, conf, age.
- Lookup: combinational match on ip_i among valid entries (at most one hit).
- Accept: an access is accepted in the cycle where acc_valid_i && acc_ready_o. All tracker updates take effect at that edge.
- Miss:
  - allocate the lowest-index invalid entry, else the entry with age==TRACKERS-1
  - set ip, last_cla=cla, stride=0, conf=0; make the entry MRU; no issue
- Hit, new stride == 0: refresh MRU only; last_cla, stride and conf unchanged; no issue.
- Hit, new stride != 0:
  - if new stride == stored stride: conf saturating +1
  - else if conf==0: stride <= new stride (conf stays 0)
  - else: conf -1, stride kept
  - last_cla <= cla; make MRU
- MRU update: entries with age < age[idx] increment; age[idx] <= 0.
- Issue decision at accept:
  - uses post-update conf and stride
  - candidates k=1..D, D=min(cfg_degree_i, MAX_DEGREE)
  - cand_k = (cla + k*stride) << LOG2_BLOCK, truncated to ADDR_W
  - N = count of leading candidates with cand_k>>LOG2_PAGE == addr_i>>LOG2_PAGE; stop at the first page cross
  - if conf >= CONF_THRESH and N > 0: latch base cla, stride and N; FSM -> ISSUE; otherwise stay IDLE
- FSM:
  - IDLE: acc_ready_o=1, pref_valid_o=0.
  - ISSUE:
    - acc_ready_o=0; pref_valid_o=1 with pref_addr_o=cand_k, starting at k=1 in the cycle after accept
    - pref_addr_o is stable while pref_ready_i=0
    - each handshake advances k
    - the handshake on k==N returns to IDLE; acc_ready_o=1 the next cycle
- Latency: first prefetch valid 1 cycle after accept. Throughput is 1 prefetch per cycle under pref_ready_i=1.
- A new access is never accepted in the same cycle as the last prefetch handshake.

Optional Feature:
- Macro PREF_CROSS_PAGE_EN.
- Defined: the page filter is removed and N=D; candidates wrap modulo 2^ADDR_W.
- Undefined: same-page filter exactly as above.

Decomposition:
- Package ip_stride_pkg holds:
  - ADDR_W, LOG2_BLOCK, LOG2_PAGE defaults
  - cla_t, stride_t (signed), conf_t
  - tracker_t struct
  - pf_state_e {IDLE, ISSUE}
- Sub-module ip_stride_tracker_table: lookup, allocation, age-based LRU, and stride/confidence update. It outputs hit stride/conf post-update.
- The top holds the issue FSM and address generation.

Test Plan:
- Reset: assert rst mid-ISSUE with pref_valid_o=1 -> pref_valid_o=0 immediately and acc_ready_o=1; tracker state cleared, so re-training is required.
- Training, ip=0x400, degree=2, pref_ready_i=1:
  - addrs 0x1000, 0x1040, 0x1080, 0x10C0 -> no prefetch after the first three
  - after 0x10C0: pref_addr_o=0x1100 then 0x1140 on consecutive cycles
- Backpressure: same as the training test with pref_ready_i=0 for 3 cycles -> pref_addr_o holds 0x1100, acc_ready_o=0, and a presented access is not accepted until the final handshake.
- Page filter:
  - trained ip, stride +1 line, trigger 0x1FC0 -> no prefetch, acc_ready_o stays 1
  - with PREF_CROSS_PAGE_EN: 0x2000, 0x2040 issued
- Negative stride, degree=2: addrs 0x3100, 0x30C0, 0x3080, 0x3040 -> only 0x3000 issued (0x2FC0 crosses the page).
- LRU, TRACKERS=4: ips A, B, C, D, E each accessed once -> E evicts A; A re-accessed is a miss with conf=0; B..D retained.
